alu_pipe_md: RTL and testbench
==============================

Name: alu_pipe_md

Overview:
- Parametrised, registered successor to the execute-stage combinational ALU.
- Keeps the base integer opcode set at 1-cycle latency.
- Adds the RV32M multiply/divide ops as iterative multi-cycle operations.
- Uses a valid/ready handshake and a flush input, so the EX stage can stall on long ops and kill them on redirect.

Parameters:
- XLEN, 32: operand/result width; must be a power of two, 8 or more.
- ENABLE_M, 1: when 0, M opcodes complete in 1 cycle with result 0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  sync kill of the in-flight op; no result is produced for it
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept this cycle
- operand_a  in  XLEN  source A
- operand_b  in  XLEN  source B
- alu_controller  in  5  opcode
- out_valid  out  1  alu_data valid
- out_ready  in  1  consumer takes the result
- alu_data  out  XLEN  result
- busy  out  1  high in state CALC

Behaviour:
- Opcodes (unlisted codes give 0 with 1-cycle latency):
  - Base: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT, 8 SLTU, 9 SRA, 15 pass operand_b.
  - M: 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
- Shift amount is operand_b[$clog2(XLEN)-1:0].
- All arithmetic is mod 2^XLEN. Signedness follows the RV32M definitions.
- Accept event: in_valid & in_ready at a clock edge. Operands and opcode are captured in internal registers; inputs are don't-care afterwards.
- FSM states: IDLE, CALC, DONE.
  - IDLE: accept of a base op, a special case, or any M op with ENABLE_M=0 → DONE, with alu_data registered at the same edge.
  - IDLE: accept of an M op → CALC and cycle counter = 0.
  - CALC: counter increments each cycle. At counter = XLEN-1 → DONE, with the result written to alu_data.
  - DONE: out_valid=1. alu_data stays stable until out_ready.
  - DONE with out_ready=1: back to IDLE, or directly into the next op if an accept happens in the same cycle.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This gives back-to-back throughput of 1 op/cycle for base ops.
- Latency from the accept edge to out_valid:
  - Base ops: 1 cycle.
  - M ops: XLEN+1 cycles.
- Multiply datapath:
  - Radix-2 shift-add on magnitudes with a 2*XLEN accumulator.
  - Sign correction by two's-complement negation of the product, where the operand signs require it.
  - MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- Divide datapath:
  - Restoring, 1 quotient bit/cycle on magnitudes.
  - Quotient sign = sign(a) XOR sign(b). Remainder takes the sign of the dividend.
- Special cases resolve at 1-cycle latency and bypass CALC:
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → operand_a.
  - Signed overflow, DIV with a = -2^(XLEN-1) and b = -1: DIV → a, REM → 0.
- flush: any state → IDLE next edge, out_valid=0, and no accept that cycle (in_ready forced 0 while flush=1). The datapath state is abandoned.
- Reset (rst_n=0 at an edge):
  - Takes priority over flush and accept, including mid-CALC.
  - Reset values: state=IDLE, out_valid=0, alu_data=0, busy=0, counter=0.
  - in_ready=0 while rst_n=0, then 1 from the first cycle after release.
- out_ready asserted while out_valid=0 has no effect.
- out_valid never drops without a handshake, flush or reset.

Test Plan (XLEN=32):
- Reset: assert rst_n=0 mid-CALC of a DIVU → next cycle out_valid=0, alu_data=0, busy=0; after release, in_ready=1.
- Base back-to-back, out_ready=1:
  - Issue ADD 5,7, then SRA 0x80000000,4, then SLT 0xFFFFFFFF,1 on consecutive cycles.
  - Required: results 12, 0xF8000000, 1 on three consecutive out_valid cycles starting 1 cycle after the first accept.
- Multiply, each result exactly 33 cycles after accept with busy high for 32 cycles:
  - MUL 0xFFFFFFFF,0xFFFFFFFF → 1.
  - MULH 0x80000000,0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF,2 → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF,0xFFFFFFFF → 0xFFFFFFFE.
- Divide:
  - DIV -7,2 → 0xFFFFFFFD; REM -7,2 → 0xFFFFFFFF (latency 33).
  - DIVU 10,0 → 0xFFFFFFFF and REMU 10,0 → 10 (latency 1).
  - DIV 0x80000000,0xFFFFFFFF → 0x80000000 and REM same operands → 0 (latency 1).
- Backpressure: complete a MUL 3,4 with out_ready=0 for 5 cycles → out_valid and alu_data=12 held, in_ready=0; raise out_ready → handshake, then IDLE.
- Flush: flush at cycle 10 of a DIV → next cycle IDLE, no out_valid for that op; then a following ADD 1,1 → 2 at 1-cycle latency.

Source files
------------

// File: rtl/alu_pipe_md.sv
// rtl/alu_pipe_md.sv - registered execute-stage ALU with iterative multiply/divide
//
// Single-cycle base integer ops and multi-cycle shift-add multiply and restoring divide
// share one valid/ready result slot. A flush kills whatever op is in flight.
//
// Ports:
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   flush           abandon the in-flight op, no result is produced for it
//   in_valid        operands and opcode valid
//   in_ready        an op can be accepted this cycle
//   operand_a/b     XLEN-bit sources
//   alu_controller  5-bit opcode
//   out_valid       alu_data holds a result
//   out_ready       consumer takes the result
//   alu_data        XLEN-bit result
//   busy            an iterative op is computing
module alu_pipe_md #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      alu_controller,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_data,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SLT  = 5'd7;
  localparam logic [4:0] OP_SLTU = 5'd8;
  localparam logic [4:0] OP_SRA  = 5'd9;
  localparam logic [4:0] OP_PASS = 5'd15;

  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);

  logic [1:0]        state_q, state_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]   alu_data_q, alu_data_d;
  // Multiply: {partial product high, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        mop_q, mop_d;
  // Set when the selected result must be negated at the end.
  logic              neg_q, neg_d;

  // Issue-side decode.
  logic            accept;
  logic [2:0]      mop_in;
  logic            is_m, m_div, m_rem, m_uns;
  logic            b_zero, div_ovf, special, start_calc;
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] quick_res;
  logic [SHW-1:0]  shamt;

  // Iteration datapath.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh, rem_diff;
  logic [2*XLEN-1:0] step, prod_fix;
  logic [XLEN-1:0]   div_sel, div_fix, calc_res;

  assign in_ready  = rst_n & ~flush &
                     ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CALC);
  assign alu_data  = alu_data_q;

  assign mop_in = alu_controller[2:0];
  assign is_m   = (alu_controller[4:3] == 2'b10);
  assign m_div  = mop_in[2];
  assign m_rem  = mop_in[1];
  assign m_uns  = mop_in[0];
  assign shamt  = operand_b[SHW-1:0];

  assign b_zero     = (operand_b == '0);
  assign div_ovf    = m_div & ~m_uns & (operand_a == INT_MIN) & (operand_b == ALL_ONES);
  assign special    = is_m & m_div & (b_zero | div_ovf);
  assign start_calc = is_m & (ENABLE_M != 0) & ~special;

  // MUL has the same low half signed or unsigned, so it runs unsigned.
  assign a_sgn = m_div ? ~m_uns : ((mop_in == 3'b001) | (mop_in == 3'b010));
  assign b_sgn = m_div ? ~m_uns : (mop_in == 3'b001);
  assign a_neg = a_sgn & operand_a[XLEN-1];
  assign b_neg = b_sgn & operand_b[XLEN-1];
  assign mag_a = a_neg ? -operand_a : operand_a;
  assign mag_b = b_neg ? -operand_b : operand_b;

  always_comb begin
    quick_res = '0;
    case (alu_controller)
      OP_ADD:  quick_res = operand_a + operand_b;
      OP_SUB:  quick_res = operand_a - operand_b;
      OP_AND:  quick_res = operand_a & operand_b;
      OP_OR:   quick_res = operand_a | operand_b;
      OP_XOR:  quick_res = operand_a ^ operand_b;
      OP_SLL:  quick_res = operand_a << shamt;
      OP_SRL:  quick_res = operand_a >> shamt;
      OP_SLT:  quick_res = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      OP_SLTU: quick_res = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
      OP_SRA:  quick_res = $unsigned($signed(operand_a) >>> shamt);
      OP_PASS: quick_res = operand_b;
      default: begin
        // Divide corner cases resolve here; with M disabled every M op yields 0.
        if (special && (ENABLE_M != 0)) begin
          if (b_zero) quick_res = m_rem ? operand_a : ALL_ONES;
          else        quick_res = m_rem ? '0 : operand_a;
        end
      end
    endcase
  end

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    rem_diff = rem_sh - {1'b0, opnd_q};
    if (!mop_q[2]) begin
      step = {mul_sum, acc_q[XLEN-1:1]};
    end else if (!rem_diff[XLEN]) begin
      // No borrow: divisor fits, keep the difference and shift in a 1.
      step = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end

    prod_fix = neg_q ? -step : step;
    div_sel  = mop_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
    div_fix  = neg_q ? -div_sel : div_sel;

    if (mop_q[2])            calc_res = div_fix;
    else if (mop_q == 3'b000) calc_res = prod_fix[XLEN-1:0];
    else                     calc_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_data_d = alu_data_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    mop_d      = mop_q;
    neg_d      = neg_q;

    case (state_q)
      S_IDLE: ;
      S_CALC: begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d    = S_DONE;
          alu_data_d = calc_res;
          cnt_d      = '0;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // An accept in DONE overrides the return to IDLE above.
    if (accept) begin
      mop_d = mop_in;
      if (start_calc) begin
        state_d = S_CALC;
        cnt_d   = '0;
        acc_d   = m_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
        opnd_d  = m_div ? mag_b : mag_a;
        neg_d   = (m_div & m_rem) ? a_neg : (a_neg ^ b_neg);
      end else begin
        state_d    = S_DONE;
        alu_data_d = quick_res;
      end
    end

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      alu_data_q <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      mop_q      <= '0;
      neg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_data_q <= alu_data_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      mop_q      <= mop_d;
      neg_q      <= neg_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe_md.sv
// tb/tb_alu_pipe_md.sv - self-checking bench for alu_pipe_md with a behavioural result model
module tb_alu_pipe_md;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] operand_a, operand_b;
  logic [4:0]  alu_controller;
  logic        in_ready, out_valid, busy;
  logic [31:0] alu_data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_pipe_md #(.XLEN(32), .ENABLE_M(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .alu_controller (alu_controller),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .alu_data       (alu_data),
    .busy           (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result from the instruction-set definitions.
  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    r = '0;
    p = '0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = a ^ b;
      5'd5:  r = a << b[4:0];
      5'd6:  r = a >> b[4:0];
      5'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd8:  r = (a < b) ? 32'd1 : 32'd0;
      5'd9:  r = $unsigned($signed(a) >>> b[4:0]);
      5'd15: r = b;
      5'd16: r = a * b;
      5'd17: begin p = $unsigned(longint'($signed(a)) * longint'($signed(b))); r = p[63:32]; end
      5'd18: begin p = $unsigned(longint'($signed(a)) * longint'({32'd0, b})); r = p[63:32]; end
      5'd19: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      5'd20: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
        else r = $unsigned($signed(a) / $signed(b));
      end
      5'd21: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      5'd22: begin
        if (b == 0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
        else r = $unsigned($signed(a) % $signed(b));
      end
      5'd23: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic is_long(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 5'd16 || op > 5'd23) return 1'b0;
    if (op >= 5'd20 && b == 0) return 1'b0;
    if ((op == 5'd20 || op == 5'd22) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1'b0;
    return 1'b1;
  endfunction

  // Model: one result slot plus a countdown for long ops.
  logic        m_valid = 1'b0, m_busy = 1'b0, m_zero = 1'b1, chk_en = 1'b0;
  int          m_wait  = 0;
  logic [31:0] m_data  = '0, m_pend = '0;

  function automatic logic exp_ready();
    return rst_n && !flush && !m_busy && (!m_valid || out_ready);
  endfunction

  always @(posedge clk) begin
    logic take;
    take = in_valid && exp_ready();
    if (!rst_n) begin
      m_valid = 1'b0; m_busy = 1'b0; m_zero = 1'b1; chk_en = 1'b1;
    end else if (flush) begin
      m_valid = 1'b0; m_busy = 1'b0;
    end else begin
      if (m_valid && out_ready) m_valid = 1'b0;
      if (m_busy) begin
        m_wait--;
        if (m_wait == 0) begin
          m_busy = 1'b0; m_valid = 1'b1; m_data = m_pend; m_zero = 1'b0;
        end
      end
      if (take) begin
        if (is_long(alu_controller, operand_a, operand_b)) begin
          m_busy = 1'b1; m_wait = 32;
          m_pend = ref_result(alu_controller, operand_a, operand_b);
        end else begin
          m_valid = 1'b1; m_zero = 1'b0;
          m_data  = ref_result(alu_controller, operand_a, operand_b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("in_ready", 32'(in_ready), 32'(exp_ready()));
      if (m_valid || m_zero) chk("alu_data", alu_data, m_valid ? m_data : 32'd0);
    end
  end

  // Issue one op with out_ready=1 and check its result, latency and busy cycles.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_val, input int exp_lat, input int exp_busy,
                        input string nm);
    int lat, guard, busy_n;
    guard = 0;
    while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    in_valid = 1'b1; alu_controller = op; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; operand_a = $urandom; operand_b = $urandom;
    lat = 1;
    busy_n = busy ? 1 : 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_n++;
    end
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_data"}, alu_data, exp_val);
    chk({nm, "_busy"}, 32'(busy_n), 32'(exp_busy));
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom % 6)
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFFFFFF;
      3: v = 32'h80000000;
      4: v = $urandom % 16;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen, guard, sel;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    operand_a = '0; operand_b = '0; alu_controller = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_data", alu_data, 32'd0);
    chk("rst_in_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready_high", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Base back-to-back.
    in_valid = 1'b1; alu_controller = 5'd0; operand_a = 32'd5; operand_b = 32'd7;
    @(posedge clk); #1;
    chk("b2b_add_v", 32'(out_valid), 32'd1);
    chk("b2b_add", alu_data, 32'd12);
    alu_controller = 5'd9; operand_a = 32'h80000000; operand_b = 32'd4;
    @(posedge clk); #1;
    chk("b2b_sra_v", 32'(out_valid), 32'd1);
    chk("b2b_sra", alu_data, 32'hF8000000);
    alu_controller = 5'd7; operand_a = 32'hFFFFFFFF; operand_b = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_slt_v", 32'(out_valid), 32'd1);
    chk("b2b_slt", alu_data, 32'd1);

    // Multiply and divide, literal expectations.
    run_op(5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 33, 32, "mul");
    run_op(5'd17, 32'h80000000, 32'h80000000, 32'h40000000, 33, 32, "mulh");
    run_op(5'd18, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33, 32, "mulhsu");
    run_op(5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 32, "mulhu");
    run_op(5'd20, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 32, "div");
    run_op(5'd22, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 32, "rem");
    run_op(5'd21, 32'd10, 32'd0, 32'hFFFFFFFF, 1, 0, "divu_z");
    run_op(5'd23, 32'd10, 32'd0, 32'd10, 1, 0, "remu_z");
    run_op(5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, "div_ovf");
    run_op(5'd22, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 0, "rem_ovf");
    run_op(5'd21, 32'd100, 32'd7, 32'd14, 33, 32, "divu");
    run_op(5'd10, 32'd3, 32'd4, 32'd0, 1, 0, "unlisted");
    @(posedge clk); #1;

    // Reset mid-CALC of a DIVU.
    in_valid = 1'b1; alu_controller = 5'd21; operand_a = 32'd1000; operand_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_alu_data", alu_data, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Backpressure on a MUL result.
    out_ready = 1'b0;
    in_valid = 1'b1; alu_controller = 5'd16; operand_a = 32'd3; operand_b = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin @(posedge clk); #1; guard++; end
    chk("bp_lat", 32'(guard + 1), 32'd33);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", alu_data, 32'd12);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_busy", 32'(busy), 32'd0);

    // Flush during a DIV.
    in_valid = 1'b1; alu_controller = 5'd20; operand_a = 32'd100; operand_b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1; alu_controller = 5'd0; operand_a = 32'd9; operand_b = 32'd9;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("flush_no_result", 32'(seen), 32'd0);
    run_op(5'd0, 32'd1, 32'd1, 32'd2, 1, 0, "post_flush_add");

    // Randomised traffic checked by the model every cycle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      rst_n     = ($urandom % 600) != 0;
      flush     = ($urandom % 80) == 0;
      out_ready = ($urandom % 4) != 0;
      in_valid  = ($urandom % 3) != 0;
      operand_a = pick();
      operand_b = pick();
      sel = $urandom % 10;
      if (sel < 3)       alu_controller = 5'(16 + ($urandom % 8));
      else if (sel == 3) alu_controller = 5'($urandom % 32);
      else begin
        sel = $urandom % 11;
        alu_controller = (sel == 10) ? 5'd15 : 5'(sel);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
